// File: rtl/writeback_arbiter.sv
// Writeback arbiter: merges single-cycle ALU results with FIFO-buffered LSU results
// onto one register-file write port, with starvation stall and hazard lookup.

module writeback_arbiter_checker (
   input logic clk,
   input logic rst,
   input logic alu_valid,
   input logic alu_stall
);
   // Upstream must hold off ALU results while a stall is requested
   property p_no_alu_during_stall;
      @(posedge clk) disable iff (rst) alu_stall |-> !alu_valid;
   endproperty
   a_no_alu_during_stall: assert property (p_no_alu_during_stall);
endmodule

module writeback_arbiter #(
   parameter int XLEN         = 32,
   parameter int DEPTH        = 4,
   parameter int STARVE_LIMIT = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            alu_valid,
   input  logic [4:0]      alu_rd,
   input  logic [XLEN-1:0] alu_result,
   input  logic            lsu_valid,
   output logic            lsu_ready,
   input  logic [4:0]      lsu_rd,
   input  logic [XLEN-1:0] lsu_data,
   output logic            alu_stall,
   input  logic [4:0]      read_addr1,
   input  logic [4:0]      read_addr2,
   output logic            rd_pending1,
   output logic            rd_pending2,
   output logic            reg_write_en,
   output logic [4:0]      write_addr,
   output logic [XLEN-1:0] write_data
);
   localparam int PTR_W  = $clog2(DEPTH);
   localparam int CNT_W  = PTR_W + 1;
   localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);

   logic [4:0]      fifo_rd_r   [DEPTH];
   logic [XLEN-1:0] fifo_data_r [DEPTH];
   logic [PTR_W-1:0] head_r;
   logic [PTR_W-1:0] tail_r;
   logic [CNT_W-1:0] count_r;
   logic [WAIT_W-1:0] wait_cnt_r;
   logic              alu_stall_r;
   logic              reg_write_en_r;
   logic [4:0]        write_addr_r;
   logic [XLEN-1:0]   write_data_r;

   logic              full_s;
   logic              empty_s;
   logic              push_s;
   logic              pop_s;
   logic [DEPTH-1:0]  occupied_s;
   logic [PTR_W-1:0]  offset_s;
   logic              hit1_s;
   logic              hit2_s;

   assign full_s  = (count_r == CNT_W'(DEPTH));
   assign empty_s = (count_r == CNT_W'(0));
   // rd==0 results are acknowledged but never stored
   assign push_s  = lsu_valid && !full_s && (lsu_rd != 5'd0);
   assign pop_s   = !alu_valid && !empty_s;

   assign lsu_ready    = !full_s;
   assign alu_stall    = alu_stall_r;
   assign reg_write_en = reg_write_en_r;
   assign write_addr   = write_addr_r;
   assign write_data   = write_data_r;

   // FIFO storage, written at the tail on push
   always_ff @(posedge clk) begin
      if (push_s) begin
         fifo_rd_r[tail_r]   <= lsu_rd;
         fifo_data_r[tail_r] <= lsu_data;
      end
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clk) begin
      if (rst) begin
         head_r  <= '0;
         tail_r  <= '0;
         count_r <= '0;
      end else begin
         if (push_s) tail_r <= tail_r + PTR_W'(1);
         if (pop_s)  head_r <= head_r + PTR_W'(1);
         count_r <= count_r + CNT_W'(push_s) - CNT_W'(pop_s);
      end
   end

   // Register-file write port: ALU first, otherwise drain the FIFO head
   always_ff @(posedge clk) begin
      if (rst) begin
         reg_write_en_r <= 1'b0;
         write_addr_r   <= 5'd0;
         write_data_r   <= '0;
      end else if (alu_valid) begin
         reg_write_en_r <= (alu_rd != 5'd0);
         write_addr_r   <= alu_rd;
         write_data_r   <= alu_result;
      end else if (!empty_s) begin
         reg_write_en_r <= (fifo_rd_r[head_r] != 5'd0);
         write_addr_r   <= fifo_rd_r[head_r];
         write_data_r   <= fifo_data_r[head_r];
      end else begin
         reg_write_en_r <= 1'b0;
      end
   end

   // Starvation counter and the registered stall request it drives
   always_ff @(posedge clk) begin
      if (rst) begin
         wait_cnt_r  <= '0;
         alu_stall_r <= 1'b0;
      end else begin
         if (empty_s || pop_s) begin
            wait_cnt_r <= '0;
         end else if (wait_cnt_r != WAIT_W'(STARVE_LIMIT)) begin
            wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
         end
         alu_stall_r <= (wait_cnt_r == WAIT_W'(STARVE_LIMIT)) && !pop_s;
      end
   end

   // Hazard lookup over live FIFO slots and the in-flight write
   always_comb begin
      occupied_s = '0;
      offset_s   = '0;
      hit1_s     = 1'b0;
      hit2_s     = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         offset_s      = PTR_W'(i) - head_r;
         occupied_s[i] = ({1'b0, offset_s} < count_r);
         hit1_s = hit1_s | (occupied_s[i] && (fifo_rd_r[i] == read_addr1));
         hit2_s = hit2_s | (occupied_s[i] && (fifo_rd_r[i] == read_addr2));
      end
      rd_pending1 = (read_addr1 != 5'd0) &&
                    (hit1_s || (reg_write_en_r && (write_addr_r == read_addr1)));
      rd_pending2 = (read_addr2 != 5'd0) &&
                    (hit2_s || (reg_write_en_r && (write_addr_r == read_addr2)));
   end

   writeback_arbiter_checker u_checker (
      .clk       (clk),
      .rst       (rst),
      .alu_valid (alu_valid),
      .alu_stall (alu_stall_r)
   );
endmodule
